// File: rtl/wb_select_stage_if.sv
// Writeback-stage bus: instruction-side inputs from the previous stage and
// registered results headed for the register file.
interface wb_select_stage_if #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 4,
    parameter int SELW  = 2,
    parameter int REGW  = 5,
    parameter int CNTW  = 32
);
    logic                   ValidIn;
    logic                   Stall;
    logic                   Flush;
    logic [SELW-1:0]        WBSel;
    logic [NSRC*WIDTH-1:0]  SrcData;
    logic [2:0]             LoadType;
    logic [1:0]             ByteOffset;
    logic                   RegWriteIn;
    logic [REGW-1:0]        WriteRegIn;

    logic [WIDTH-1:0]       WriteData;
    logic [REGW-1:0]        WriteReg;
    logic                   RegWrite;
    logic                   ValidOut;
    logic                   AlignErr;
    logic [CNTW-1:0]        RetireCount;

    modport master (
        output ValidIn, Stall, Flush, WBSel, SrcData, LoadType, ByteOffset,
               RegWriteIn, WriteRegIn,
        input  WriteData, WriteReg, RegWrite, ValidOut, AlignErr, RetireCount
    );

    modport slave (
        input  ValidIn, Stall, Flush, WBSel, SrcData, LoadType, ByteOffset,
               RegWriteIn, WriteRegIn,
        output WriteData, WriteReg, RegWrite, ValidOut, AlignErr, RetireCount
    );
endinterface

// File: rtl/wb_select_stage.sv
// Registered writeback stage: source select, load lane extraction with sign/zero
// extension, alignment check, and a retired-write counter.
module wb_select_stage #(
    parameter int WIDTH   = 32,
    parameter int NSRC    = 4,
    parameter int SELW    = 2,
    parameter int MEM_IDX = 1,
    parameter int REGW    = 5,
    parameter int CNTW    = 32
) (
    input  logic              clock,
    input  logic              reset,
    wb_select_stage_if.slave  bus
);
    localparam int              NSLOT  = 1 << SELW;
    localparam logic [SELW-1:0] MEMSEL = SELW'(MEM_IDX);

    // Every select code maps to a slot; codes past NSRC read as zero.
    logic [WIDTH-1:0] srcSlot [NSLOT];

    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : gSlot
            if (gi < NSRC) begin : gLive
                assign srcSlot[gi] = bus.SrcData[gi*WIDTH +: WIDTH];
            end else begin : gZero
                assign srcSlot[gi] = '0;
            end
        end
    endgenerate

    logic [WIDTH-1:0] selData;
    logic [WIDTH-1:0] dataNext;
    logic [7:0]       byteLane;
    logic [15:0]      halfLane;
    logic             isMem;
    logic             isByte;
    logic             isHalf;
    logic             isSigned;
    logic             misaligned;
    logic             regWriteNext;

    always_comb begin
        selData  = srcSlot[bus.WBSel];
        isMem    = (bus.WBSel == MEMSEL);
        isByte   = (bus.LoadType == 3'd1) || (bus.LoadType == 3'd2);
        isHalf   = (bus.LoadType == 3'd3) || (bus.LoadType == 3'd4);
        isSigned = (bus.LoadType == 3'd1) || (bus.LoadType == 3'd3);
        byteLane = selData[8*bus.ByteOffset +: 8];
        halfLane = selData[16*bus.ByteOffset[1] +: 16];

        dataNext   = selData;
        misaligned = 1'b0;
        if (isMem) begin
            if (isByte) begin
                dataNext = {{(WIDTH-8){isSigned & byteLane[7]}}, byteLane};
            end else if (isHalf) begin
                dataNext   = {{(WIDTH-16){isSigned & halfLane[15]}}, halfLane};
                misaligned = bus.ByteOffset[0];
            end else begin
                misaligned = (bus.ByteOffset != 2'd0);
            end
        end

        // $0 is hardwired; never emit a write to it.
        regWriteNext = bus.ValidIn & bus.RegWriteIn & ~misaligned
                     & (bus.WriteRegIn != '0);
    end

    logic [WIDTH-1:0] writeDataReg;
    logic [REGW-1:0]  writeRegReg;
    logic             regWriteReg;
    logic             validOutReg;
    logic             alignErrReg;
    logic [CNTW-1:0]  retireCountReg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            writeDataReg   <= '0;
            writeRegReg    <= '0;
            regWriteReg    <= 1'b0;
            validOutReg    <= 1'b0;
            alignErrReg    <= 1'b0;
            retireCountReg <= '0;
        end else if (bus.Flush) begin
            // Squash control only; data/destination keep their last value.
            validOutReg <= 1'b0;
            regWriteReg <= 1'b0;
            alignErrReg <= 1'b0;
        end else if (!bus.Stall) begin
            validOutReg  <= bus.ValidIn;
            writeDataReg <= dataNext;
            writeRegReg  <= bus.WriteRegIn;
            regWriteReg  <= regWriteNext;
            alignErrReg  <= bus.ValidIn & misaligned;
            if (regWriteNext) begin
                retireCountReg <= retireCountReg + CNTW'(1);
            end
        end
    end

    assign bus.WriteData   = writeDataReg;
    assign bus.WriteReg    = writeRegReg;
    assign bus.RegWrite    = regWriteReg;
    assign bus.ValidOut    = validOutReg;
    assign bus.AlignErr    = alignErrReg;
    assign bus.RetireCount = retireCountReg;

endmodule
